ingame_round_ctrl: RTL
======================

// Module: ingame_round_ctrl
// PURPOSE
//  In-game round engine: the counterpart to the game-mode FSM. Consumes its ingameOn level, runs one
//  tile-matching round (countdown timer, pairs remaining, score) and reports round end on gameOver.
//  Sits between the game-mode FSM and the board/match logic; feeds HEX/VGA status displays.
// PARAMETERS
//  CLK_HZ        50_000_000  clock cycles per game second (prescaler terminal count)
//  ROUND_SECONDS 60          round length in seconds, 1..127
//  NUM_PAIRS     8           tile pairs per board, 1..15
//  MATCH_POINTS  10          score added per matched pair
//  MISS_PENALTY  2           seconds removed per mismatch (MISS_PENALTY_EN only)
// PORTS
//  CLOCK_50   in   1  system clock, all logic on posedge
//  resetn     in   1  asynchronous, active-low reset
//  ingameOn   in   1  level from game-mode FSM; high = round may run
//  matchPulse in   1  one-cycle pulse: a pair was matched
//  missPulse  in   1  one-cycle pulse: a mismatch was revealed
//  gameOver   out  1  registered; high while round has ended (state OVER)
//  gameWon    out  1  registered; high in OVER if all pairs were matched
//  timeLeft   out  7  seconds remaining
//  pairsLeft  out  4  unmatched pairs remaining
//  score      out  8  round score, saturates at 255
//  secTick    out  1  one-cycle pulse each game second while PLAYING
// BEHAVIOUR
//  Reset (resetn=0, async): state IDLE; gameOver=0, gameWon=0, timeLeft=0, pairsLeft=0, score=0,
//   secTick=0, prescaler=0.
//  States: IDLE, PLAYING, OVER (2-bit register).
//  IDLE: gameOver=0. On edge with ingameOn=1 -> PLAYING, same edge loads timeLeft=ROUND_SECONDS,
//   pairsLeft=NUM_PAIRS, score=0, gameWon=0, prescaler=0. Counters otherwise hold last values.
//  PLAYING: prescaler counts 0..CLK_HZ-1; at CLK_HZ-1 it wraps to 0, secTick=1 for that cycle,
//   timeLeft decrements (saturating at 0). First tick CLK_HZ cycles after entry.
//   matchPulse: pairsLeft-1 (never below 0), score+MATCH_POINTS saturating at 255.
//   Match and tick in the same cycle: both applied.
//   End: on the edge where pairsLeft becomes 0 -> OVER, gameWon=1, gameOver=1.
//   On the edge where timeLeft becomes 0 (pairsLeft>0) -> OVER, gameWon=0, gameOver=1.
//   Both reach 0 on the same edge: win takes priority (gameWon=1).
//   Pulses ignored outside PLAYING. ingameOn=0 in PLAYING (user quit): -> IDLE next edge,
//   gameOver stays 0, counters frozen.
//  OVER: gameOver=1, all counters frozen, pulses ignored. ingameOn=0 -> IDLE (gameOver=0 next edge).
//   ingameOn staying 1 holds OVER indefinitely (no auto-restart).
//  gameOver latency: asserted on the same edge the terminal counter value is registered.
// CONFIGURATION
//  MISS_PENALTY_EN defined: missPulse in PLAYING subtracts MISS_PENALTY from timeLeft, saturating at
//   0; if applied with a tick in the same cycle, subtract MISS_PENALTY+1 (saturating); reaching 0 via
//   penalty ends round as a loss (unless last pair matched same cycle -> win).
//  MISS_PENALTY_EN undefined: missPulse ignored entirely; no penalty logic synthesised.
// TESTING (CLK_HZ=4, ROUND_SECONDS=5, NUM_PAIRS=3)
//  Reset mid-run: resetn low while PLAYING -> all outputs 0, state IDLE immediately (async).
//  Timeout: ingameOn=1, no pulses -> secTick every 4 cycles, timeLeft 5..0, gameOver=1 gameWon=0
//   on edge timeLeft=0; ingameOn=0 -> gameOver=0 one cycle later.
//  Win: 3 matchPulses within 10 cycles -> pairsLeft 3,2,1,0, score 10,20,30, gameOver=1 gameWon=1.
//  Tie: third match on same cycle as final tick -> gameWon=1, timeLeft=0, pairsLeft=0.
//  Quit: ingameOn=0 after 6 cycles in PLAYING -> IDLE, gameOver never asserts, timeLeft=4 held.
//  MISS_PENALTY_EN: missPulse at timeLeft=3 -> timeLeft=1; second miss -> 0, gameOver=1 gameWon=0;
//   without macro same stimulus leaves timeLeft unchanged.

Source files
------------

// File: rtl/ingame_round_ctrl.sv
// ---------------------------------------------------------------------------
// ingame_round_ctrl
//   In-game round engine driven by the game-mode FSM's ingameOn level. Runs
//   one tile-matching round with a countdown timer, a pairs-remaining counter
//   and a saturating score. It reports the end of the round on gameOver and
//   reports a win on gameWon.
//
//   Optional feature: define MISS_PENALTY_EN to make missPulse remove
//   MISS_PENALTY seconds from the timer. When the macro is undefined,
//   missPulse is ignored and no penalty logic is built.
//
// Ports
//   CLOCK_50   in   system clock, all logic on posedge
//   resetn     in   asynchronous active-low reset
//   ingameOn   in   high = round may run (low quits / leaves OVER)
//   matchPulse in   one-cycle pulse, a pair was matched
//   missPulse  in   one-cycle pulse, a mismatch was revealed
//   gameOver   out  registered, high while in OVER
//   gameWon    out  registered, high in OVER when all pairs were matched
//   timeLeft   out  seconds remaining [6:0]
//   pairsLeft  out  unmatched pairs remaining [3:0]
//   score      out  round score, saturating at 255 [7:0]
//   secTick    out  one-cycle pulse per game second while PLAYING
// ---------------------------------------------------------------------------
module ingame_round_ctrl #(
    parameter int CLK_HZ        = 50_000_000,
    parameter int ROUND_SECONDS = 60,
    parameter int NUM_PAIRS     = 8,
    parameter int MATCH_POINTS  = 10,
    parameter int MISS_PENALTY  = 2
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic       ingameOn,
    input  logic       matchPulse,
    input  logic       missPulse,
    output logic       gameOver,
    output logic       gameWon,
    output logic [6:0] timeLeft,
    output logic [3:0] pairsLeft,
    output logic [7:0] score,
    output logic       secTick
);

    localparam int PRESC_W = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(CLK_HZ - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAYING = 2'd1,
        OVER    = 2'd2
    } roundState_e;

    roundState_e        state, nextState;
    logic [PRESC_W-1:0] prescaler, nextPresc;
    logic [6:0]         nextTime;
    logic [3:0]         nextPairs;
    logic [7:0]         nextScore;
    logic               nextWon;
    logic               nextTick;
    logic               tick;
    logic [7:0]         timeDec;
    logic [8:0]         scoreSum;

`ifndef MISS_PENALTY_EN
    // missPulse has no function in this build.
    logic unusedMiss;
    assign unusedMiss = missPulse;
`endif

    // NOTE: every signal driven here gets a default before the case
    // statement. Without these defaults, a path that does not assign a signal
    // would infer a latch.
    always_comb begin
        nextState = state;
        nextPresc = prescaler;
        nextTime  = timeLeft;
        nextPairs = pairsLeft;
        nextScore = score;
        nextWon   = gameWon;
        nextTick  = 1'b0;
        tick      = 1'b0;
        timeDec   = 8'd0;
        scoreSum  = 9'd0;

        case (state)
            IDLE: begin
                if (ingameOn) begin
                    nextState = PLAYING;
                    nextTime  = 7'(ROUND_SECONDS);
                    nextPairs = 4'(NUM_PAIRS);
                    nextScore = 8'd0;
                    nextWon   = 1'b0;
                    nextPresc = '0;
                end
            end

            PLAYING: begin
                if (!ingameOn) begin
                    // The user quit: return to IDLE and freeze all counters.
                    nextState = IDLE;
                end else begin
                    tick      = (prescaler == PRESC_LAST);
                    nextPresc = tick ? '0 : prescaler + 1'b1;
                    nextTick  = tick;

                    // The tick and the penalty combine into one saturating
                    // subtraction, so both apply on the same edge.
                    timeDec = {7'd0, tick};
`ifdef MISS_PENALTY_EN
                    if (missPulse) begin
                        timeDec = timeDec + 8'(MISS_PENALTY);
                    end
`endif
                    nextTime = ({1'b0, timeLeft} > timeDec) ? timeLeft - timeDec[6:0] : 7'd0;

                    if (matchPulse && (pairsLeft != 4'd0)) begin
                        nextPairs = pairsLeft - 4'd1;
                        scoreSum  = {1'b0, score} + 9'(MATCH_POINTS);
                        nextScore = scoreSum[8] ? 8'hFF : scoreSum[7:0];
                    end

                    // The win test comes first, so a final match on the
                    // expiry edge counts as a win.
                    if (nextPairs == 4'd0) begin
                        nextState = OVER;
                        nextWon   = 1'b1;
                    end else if (nextTime == 7'd0) begin
                        nextState = OVER;
                        nextWon   = 1'b0;
                    end
                end
            end

            OVER: begin
                if (!ingameOn) begin
                    nextState = IDLE;
                end
            end

            default: nextState = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments. All registers
    // then update together from their pre-edge values.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            prescaler <= '0;
            timeLeft  <= 7'd0;
            pairsLeft <= 4'd0;
            score     <= 8'd0;
            gameWon   <= 1'b0;
            gameOver  <= 1'b0;
            secTick   <= 1'b0;
        end else begin
            state     <= nextState;
            prescaler <= nextPresc;
            timeLeft  <= nextTime;
            pairsLeft <= nextPairs;
            score     <= nextScore;
            gameWon   <= nextWon;
            // Registered from the next state, so gameOver rises on the same
            // edge that registers the terminal counter value.
            gameOver  <= (nextState == OVER);
            secTick   <= nextTick;
        end
    end

endmodule
